// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute pipeline register with load-use hazard
//               detection (one bubble per hazard), EX-redirect flush, and a
//               sticky halt once EBREAK or a decode trap reaches EX.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [XLEN-1:0]  i_inst,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [5:0]       i_fmt,
    input  logic [10:0]      i_ctrl,
    input  logic             i_trap,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_ex_valid,
    output logic [XLEN-1:0]  o_ex_pc,
    output logic [XLEN-1:0]  o_ex_inst,
    output logic [XLEN-1:0]  o_ex_rs1_data,
    output logic [XLEN-1:0]  o_ex_rs2_data,
    output logic [XLEN-1:0]  o_ex_imm,
    output logic [5:0]       o_ex_fmt,
    output logic [10:0]      o_ex_ctrl,
    output logic             o_ex_halt,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // Bit positions inside the format and control vectors
    localparam int c_FMT_R    = 0;
    localparam int c_FMT_I    = 1;
    localparam int c_FMT_S    = 2;
    localparam int c_FMT_B    = 3;
    localparam int c_CTRL_REN = 4;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_ex_valid;
    logic [XLEN-1:0]  r_ex_pc;
    logic [XLEN-1:0]  r_ex_inst;
    logic [XLEN-1:0]  r_ex_rs1_data;
    logic [XLEN-1:0]  r_ex_rs2_data;
    logic [XLEN-1:0]  r_ex_imm;
    logic [5:0]       r_ex_fmt;
    logic [10:0]      r_ex_ctrl;
    logic             r_ex_halt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_ex_rd;
    logic       w_hazard;
    logic       w_id_halt;
    logic       w_load_bubble;
    logic       w_stall;
    logic       w_cnt_inc;

    // Operand usage and load-use hazard against the instruction now in EX
    always_comb begin
        w_uses_rs1 = i_fmt[c_FMT_R] | i_fmt[c_FMT_I] | i_fmt[c_FMT_S] | i_fmt[c_FMT_B];
        w_uses_rs2 = i_fmt[c_FMT_R] | i_fmt[c_FMT_S] | i_fmt[c_FMT_B];
        w_rs1      = i_inst[19:15];
        w_rs2      = i_inst[24:20];
        w_ex_rd    = r_ex_inst[11:7];
        w_hazard   = i_id_valid & r_ex_valid & r_ex_ctrl[c_CTRL_REN] &
                     (w_ex_rd != 5'd0) &
                     ((w_uses_rs1 & (w_rs1 == w_ex_rd)) |
                      (w_uses_rs2 & (w_rs2 == w_ex_rd)));
        w_id_halt  = i_id_valid & ((i_fmt == 6'd0) | i_trap);
    end

    // Next-state and pipeline-control decision, halted > flush > hazard > load
    always_comb begin
        w_state_next  = r_state;
        w_load_bubble = 1'b0;
        w_stall       = 1'b0;
        w_cnt_inc     = 1'b0;
        if (r_state == ST_HALTED) begin
            w_load_bubble = 1'b1;
            w_stall       = 1'b1;
        end else if (i_flush) begin
            w_load_bubble = 1'b1;
        end else if (w_hazard) begin
            w_load_bubble = 1'b1;
            w_stall       = 1'b1;
            w_cnt_inc     = 1'b1;
        end else if (w_id_halt) begin
            w_state_next  = ST_HALTED;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // EX pipeline register: bubble or decode capture (ctrl gated by valid)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_inst     <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_fmt      <= '0;
            r_ex_ctrl     <= '0;
            r_ex_halt     <= 1'b0;
        end else if (w_load_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_inst     <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_fmt      <= '0;
            r_ex_ctrl     <= '0;
            r_ex_halt     <= 1'b0;
        end else begin
            r_ex_valid    <= i_id_valid;
            r_ex_pc       <= i_pc;
            r_ex_inst     <= i_inst;
            r_ex_rs1_data <= i_rs1_data;
            r_ex_rs2_data <= i_rs2_data;
            r_ex_imm      <= i_imm;
            r_ex_fmt      <= i_fmt;
            r_ex_ctrl     <= i_id_valid ? i_ctrl : 11'd0;
            r_ex_halt     <= w_id_halt;
        end
    end

    // Saturating count of load-use bubbles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_cnt_inc && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign o_stall       = w_stall;
    assign o_ex_valid    = r_ex_valid;
    assign o_ex_pc       = r_ex_pc;
    assign o_ex_inst     = r_ex_inst;
    assign o_ex_rs1_data = r_ex_rs1_data;
    assign o_ex_rs2_data = r_ex_rs2_data;
    assign o_ex_imm      = r_ex_imm;
    assign o_ex_fmt      = r_ex_fmt;
    assign o_ex_ctrl     = r_ex_ctrl;
    assign o_ex_halt     = r_ex_halt;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage (CNT_W = 2 so
//               counter saturation is reachable in a few hazards).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    // Instruction encodings
    localparam logic [31:0] c_LW_X5     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] c_LW_X5_X5  = 32'h0002A283; // lw   x5,0(x5)
    localparam logic [31:0] c_LW_X0     = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] c_ADD_X5    = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] c_ADD_X0    = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] c_LUI_X5    = 32'h000282B7; // lui  x5 (rs1 field = 5)
    localparam logic [31:0] c_JAL_X5    = 32'h005282EF; // jal  x5 (rs1/rs2 fields = 5)
    localparam logic [31:0] c_EBREAK    = 32'h00100073;
    // Formats {J,U,B,S,I,R}
    localparam logic [5:0]  c_F_R = 6'b000001;
    localparam logic [5:0]  c_F_I = 6'b000010;
    localparam logic [5:0]  c_F_U = 6'b010000;
    localparam logic [5:0]  c_F_J = 6'b100000;
    // Control {RegWrite,ALUSrc1,ALUSrc2,ALUop[1:0],lui,ren,wen,MemtoReg,Jump,Branch}
    localparam logic [10:0] c_C_LW  = 11'h514;
    localparam logic [10:0] c_C_ADD = 11'h480;
    localparam logic [10:0] c_C_LUI = 11'h520;
    localparam logic [10:0] c_C_JAL = 11'h402;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [5:0]       fmt;
    logic [10:0]      ctrl;
    logic             trap;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_inst;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [5:0]       ex_fmt;
    logic [10:0]      ex_ctrl;
    logic             ex_halt;
    logic             halted;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_valid    (id_valid),
        .i_inst        (inst),
        .i_pc          (pc),
        .i_rs1_data    (rs1_data),
        .i_rs2_data    (rs2_data),
        .i_imm         (imm),
        .i_fmt         (fmt),
        .i_ctrl        (ctrl),
        .i_trap        (trap),
        .i_flush       (flush),
        .o_stall       (stall),
        .o_ex_valid    (ex_valid),
        .o_ex_pc       (ex_pc),
        .o_ex_inst     (ex_inst),
        .o_ex_rs1_data (ex_rs1_data),
        .o_ex_rs2_data (ex_rs2_data),
        .o_ex_imm      (ex_imm),
        .o_ex_fmt      (ex_fmt),
        .o_ex_ctrl     (ex_ctrl),
        .o_ex_halt     (ex_halt),
        .o_halted      (halted),
        .o_bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decode slot; data fields derived from pc
    task automatic drive(input logic v, input logic [31:0] in, input logic [5:0] f,
                         input logic [10:0] c, input logic [31:0] p,
                         input logic fl, input logic tr);
        id_valid = v;
        inst     = in;
        fmt      = f;
        ctrl     = c;
        pc       = p;
        rs1_data = 32'hA000_0000 | p;
        rs2_data = 32'hB000_0000 | p;
        imm      = 32'hC000_0000 | p;
        flush    = fl;
        trap     = tr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 6'd0, 11'd0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("rst_valid",  ex_valid,   0);
        chk("rst_stall",  stall,      0);
        chk("rst_halted", halted,     0);
        chk("rst_cnt",    bubble_cnt, 0);
        chk("rst_ctrl",   ex_ctrl,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // load x5 followed by dependent add: one bubble
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h100, 0, 0);
        chk("lw_stall", stall, 0);
        tick();
        chk("lw_valid", ex_valid, 1);
        chk("lw_inst",  ex_inst,  c_LW_X5);
        chk("lw_ctrl",  ex_ctrl,  c_C_LW);
        chk("lw_pc",    ex_pc,    32'h100);
        drive(1, c_ADD_X5, c_F_R, c_C_ADD, 32'h104, 0, 0);
        chk("haz_stall", stall, 1);
        tick();
        chk("bub_valid", ex_valid, 0);
        chk("bub_ctrl",  ex_ctrl,  0);
        chk("bub_pc",    ex_pc,    0);
        chk("bub_cnt",   bubble_cnt, 1);
        chk("post_stall", stall, 0);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_inst",  ex_inst,  c_ADD_X5);
        chk("add_rs1",   ex_rs1_data, 32'hA000_0104);
        chk("add_rs2",   ex_rs2_data, 32'hB000_0104);
        chk("add_imm",   ex_imm,      32'hC000_0104);
        chk("add_fmt",   ex_fmt,      c_F_R);

        // rd = x0 never hazards
        drive(1, c_LW_X0, c_F_I, c_C_LW, 32'h108, 0, 0);
        tick();
        drive(1, c_ADD_X0, c_F_R, c_C_ADD, 32'h10C, 0, 0);
        chk("x0_stall", stall, 0);
        tick();
        chk("x0_valid", ex_valid, 1);
        chk("x0_cnt",   bubble_cnt, 1);

        // lui / jal do not read registers
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h110, 0, 0);
        tick();
        drive(1, c_LUI_X5, c_F_U, c_C_LUI, 32'h114, 0, 0);
        chk("lui_stall", stall, 0);
        tick();
        chk("lui_fmt", ex_fmt, c_F_U);
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h118, 0, 0);
        tick();
        drive(1, c_JAL_X5, c_F_J, c_C_JAL, 32'h11C, 0, 0);
        chk("jal_stall", stall, 0);
        tick();
        chk("jal_valid", ex_valid, 1);
        chk("jal_cnt",   bubble_cnt, 1);

        // flush overrides hazard
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h120, 0, 0);
        tick();
        drive(1, c_ADD_X5, c_F_R, c_C_ADD, 32'h124, 1, 0);
        chk("fl_stall", stall, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_cnt",   bubble_cnt, 1);

        // back-to-back dependent loads, then saturation at 3
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h128, 0, 0);
        tick();
        drive(1, c_LW_X5_X5, c_F_I, c_C_LW, 32'h12C, 0, 0);
        chk("b2b1_stall", stall, 1);
        tick();
        chk("b2b1_cnt", bubble_cnt, 2);
        tick();
        chk("b2b_ld_valid", ex_valid, 1);
        drive(1, c_ADD_X5, c_F_R, c_C_ADD, 32'h130, 0, 0);
        chk("b2b2_stall", stall, 1);
        tick();
        chk("b2b2_cnt", bubble_cnt, 3);
        tick();
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h134, 0, 0);
        tick();
        drive(1, c_ADD_X5, c_F_R, c_C_ADD, 32'h138, 0, 0);
        tick();
        chk("sat_cnt", bubble_cnt, 3);

        // async reset while a stall is pending
        drive(1, c_LW_X5, c_F_I, c_C_LW, 32'h13C, 0, 0);
        tick();
        drive(1, c_ADD_X5, c_F_R, c_C_ADD, 32'h140, 0, 0);
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_valid", ex_valid, 0);
        chk("arst_cnt",   bubble_cnt, 0);
        chk("arst_inst",  ex_inst, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // invalid slot: ctrl forced zero
        drive(0, c_LW_X5, c_F_I, c_C_LW, 32'h200, 0, 0);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_ctrl",  ex_ctrl,  0);
        chk("inv_pc",    ex_pc,    32'h200);
        chk("inv_halt",  ex_halt,  0);

        // EBREAK: sticky halt
        drive(1, c_EBREAK, 6'd0, 11'd0, 32'h204, 0, 0);
        tick();
        chk("eb_halt",   ex_halt,  1);
        chk("eb_halted", halted,   1);
        chk("eb_valid",  ex_valid, 1);
        drive(1, c_ADD_X0, c_F_R, c_C_ADD, 32'h208, 0, 0);
        chk("h_stall", stall, 1);
        tick();
        chk("h_valid",  ex_valid, 0);
        chk("h_halt",   ex_halt,  0);
        chk("h_halted", halted,   1);
        drive(1, c_ADD_X0, c_F_R, c_C_ADD, 32'h20C, 1, 0);
        chk("h_fl_stall", stall, 1);
        tick();
        chk("h_fl_valid", ex_valid, 0);

        // decode trap also halts
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, c_ADD_X0, c_F_R, c_C_ADD, 32'h300, 0, 1);
        tick();
        chk("trap_halt",   ex_halt, 1);
        chk("trap_halted", halted,  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
